// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite single-beat slave RAM with byte strobes and an address window; out-of-window accesses return DECERR.
// Latency: bvalid 2 edges after the later of the AW/W handshakes; rvalid READ_LATENCY+1 edges after the AR handshake.
// Backpressure: one transaction in flight per channel; the ready stays low and bvalid/rvalid are held until the master's ready.
module axi4lite_mem_responder #(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] ERR_RDATA    = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  output logic        axi_awready_o,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  input  logic        axi_rready_i,
  output logic [15:0] wr_count_o,
  output logic [15:0] rd_count_o
);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  // 33-bit window end so a window touching 4 GiB does not wrap
  localparam logic [32:0] WIN_END = {1'b0, MEM_BASE} + (33'(MEM_WORDS) << 2);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  function automatic logic addr_hit(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, MEM_BASE}) && ({1'b0, a} < WIN_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - MEM_BASE) >> 2);
  endfunction

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] ram_q;

  // write channel state
  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [15:0] wr_count_q, wr_count_d;

  // read channel state
  r_state_e    r_state_q, r_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fetch_q, fetch_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [15:0] rd_count_q, rd_count_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_commit, r_sample;

  assign aw_hs    = axi_awvalid_i && awready_q;
  assign w_hs     = axi_wvalid_i && wready_q;
  assign b_hs     = bvalid_q && axi_bready_i;
  assign ar_hs    = axi_arvalid_i && arready_q;
  assign r_hs     = rvalid_q && axi_rready_i;
  assign w_commit = (w_state_q == W_COMMIT) && addr_hit(awaddr_q);
  // RAM is read one cycle before rvalid so the read port registers like a block RAM
  assign r_sample = (r_state_q == R_WAIT) && (cnt_q == 4'd0) && !fetch_q;

  // RAM: read-before-write, so a same-edge read and commit return the old word
  always_ff @(posedge clk_i) begin
    if (r_sample) ram_q <= mem_q[word_idx(araddr_q)];
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[word_idx(awaddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // write FSM and its registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_count_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_count_q <= wr_count_d;
    end
  end

  // write next state: wait for both AW and W, one commit cycle, then hold the response
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:   if (aw_held_q && w_held_q) w_state_d = W_COMMIT;
      W_COMMIT: w_state_d = W_RESP;
      W_RESP:   if (b_hs) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
  end

  // write outputs: capture AW/W independently, raise B after commit, retire on handshake
  always_comb begin
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_count_d = wr_count_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = axi_awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi_wdata_i;
      wstrb_d  = axi_wstrb_i;
    end
    if (w_state_q == W_COMMIT) begin
      bvalid_d = 1'b1;
      bresp_d  = addr_hit(awaddr_q) ? RESP_OKAY : RESP_DECERR;
    end
    if ((w_state_q == W_RESP) && b_hs) begin
      bvalid_d   = 1'b0;
      aw_held_d  = 1'b0;
      w_held_d   = 1'b0;
      wr_count_d = wr_count_q + 16'd1;
    end
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // read FSM and its registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      araddr_q   <= '0;
      cnt_q      <= '0;
      fetch_q    <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_count_q <= '0;
    end else begin
      r_state_q  <= r_state_d;
      araddr_q   <= araddr_d;
      cnt_q      <= cnt_d;
      fetch_q    <= fetch_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_count_q <= rd_count_d;
    end
  end

  // read next state: count down latency, fetch, then hold the response
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_WAIT;
      R_WAIT:  if ((cnt_q == 4'd0) && fetch_q) r_state_d = R_RESP;
      R_RESP:  if (r_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // read outputs: latch address, run the latency counter, present RAM or error data
  always_comb begin
    araddr_d   = araddr_q;
    cnt_d      = cnt_q;
    fetch_d    = fetch_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d = axi_araddr_i;
          cnt_d    = 4'(READ_LATENCY - 1);
        end
      end
      R_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          fetch_d  = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = addr_hit(araddr_q) ? ram_q : ERR_RDATA;
          rresp_d  = addr_hit(araddr_q) ? RESP_OKAY : RESP_DECERR;
        end
      end
      R_RESP: begin
        if (r_hs) begin
          rvalid_d   = 1'b0;
          rd_count_d = rd_count_q + 16'd1;
        end
      end
      default: ;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign axi_awready_o = awready_q;
  assign axi_wready_o  = wready_q;
  assign axi_bvalid_o  = bvalid_q;
  assign axi_bresp_o   = bresp_q;
  assign axi_arready_o = arready_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = rresp_q;
  assign wr_count_o    = wr_count_q;
  assign rd_count_o    = rd_count_q;
endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Scoreboard bench for axi4lite_mem_responder: one instance at READ_LATENCY=1, one at 5 sharing stimulus.
// Expected B/R responses are queued at issue time and popped by a monitor on each handshake.
// Latency, stall stability, boundary decode and reset behaviour are checked directly.
module tb_axi4lite_mem_responder;
  localparam int TMO = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b1, rready = 1'b1, rready5 = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] wr_count, rd_count;
  logic        awready5, wready5, bvalid5, arready5, rvalid5;
  logic [1:0]  bresp5, rresp5;
  logic [31:0] rdata5;
  logic [15:0] wr_count5, rd_count5;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  logic [1:0] eb;
  rexp_t      er;

  int n_vec = 0;
  int n_bad = 0;

  axi4lite_mem_responder u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awready_o(awready),
    .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wready_o(wready),
    .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bready_i(bready),
    .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arready_o(arready),
    .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rready_i(rready),
    .wr_count_o(wr_count), .rd_count_o(rd_count)
  );

  axi4lite_mem_responder #(.READ_LATENCY(5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awready_o(awready5),
    .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wready_o(wready5),
    .axi_bvalid_o(bvalid5), .axi_bresp_o(bresp5), .axi_bready_i(bready),
    .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arready_o(arready5),
    .axi_rvalid_o(rvalid5), .axi_rdata_o(rdata5), .axi_rresp_o(rresp5), .axi_rready_i(rready5),
    .wr_count_o(wr_count5), .rd_count_o(rd_count5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return awready;
      1: return wready;
      2: return arready;
      3: return bvalid;
      4: return rvalid;
      5: return rvalid5;
      default: return 1'b0;
    endcase
  endfunction

  // Returns k = number of posedges after the current one at which the signal is first seen high.
  task automatic wait_sig(input int w, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (sel(w)) break;
      cyc++;
      if (cyc > TMO) begin
        n_vec++;
        n_bad++;
        $display("FAIL timeout waiting on signal %0d", w);
        break;
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] rsp, input int exp_lat);
    int c;
    exp_b.push_back(rsp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig(0, c);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_sig(3, c);
    if (exp_lat > 0) chk("b_latency", 32'(c), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rsp,
                    input int exp_lat);
    int c;
    exp_r.push_back('{data: d, resp: rsp});
    araddr = a; arvalid = 1'b1;
    wait_sig(2, c);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_sig(4, c);
    if (exp_lat > 0) chk("r_latency", 32'(c), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: pop on every handshake of the READ_LATENCY=1 instance
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_b: bresp %b with empty queue", bresp);
      end else begin
        eb = exp_b.pop_front();
        chk("bresp", 32'(bresp), 32'(eb));
      end
    end
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_r: rdata %h with empty queue", rdata);
      end else begin
        er = exp_r.pop_front();
        chk("rdata", rdata, er.data);
        chk("rresp", 32'(rresp), 32'(er.resp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", 32'(awready), 1);
    chk("rel_wready", 32'(wready), 1);
    chk("rel_arready", 32'(arready), 1);

    // basic write and readback
    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 2);
    rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 2);

    // W three cycles ahead of AW, partial strobes
    exp_b.push_back(2'b00);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    wait_sig(1, c);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_first_wready_low", 32'(wready), 0);
      chk("w_first_no_bvalid", 32'(bvalid), 0);
      @(posedge clk); #1;
    end
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    wait_sig(0, c);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_sig(3, c);
    chk("w_first_b_latency", 32'(c), 2);
    @(posedge clk); #1;
    chk("wr_count_2", 32'(wr_count), 2);
    rd(32'h8000_0010, 32'hDE22_BE44, 2'b00, 2);

    // decode: out-of-window write must not alias into the RAM
    wr(32'h8000_0100, 32'h0BAD_F00D, 4'hF, 2'b00, 0);
    wr(32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 2'b11, 0);
    rd(32'h0000_0100, 32'h0000_0000, 2'b11, 2);
    rd(32'h8000_0100, 32'h0BAD_F00D, 2'b00, 0);
    wr(32'h8000_0FFF, 32'hCAFE_F00D, 4'hF, 2'b00, 0);
    rd(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 0);
    rd(32'h8000_1000, 32'h0000_0000, 2'b11, 0);
    rd(32'h7FFF_FFFC, 32'h0000_0000, 2'b11, 0);

    // READ_LATENCY=5 instance with a stalled master
    repeat (10) @(posedge clk);
    #1;
    chk("rl5_arready_idle", 32'(arready5), 1);
    rready5 = 1'b0;
    exp_r.push_back('{data: 32'hDE22_BE44, resp: 2'b00});
    araddr = 32'h8000_0010; arvalid = 1'b1;
    wait_sig(2, c);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_sig(5, c);
    chk("rl5_latency", 32'(c), 6);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("rl5_stall_rvalid", 32'(rvalid5), 1);
      chk("rl5_stall_rdata", rdata5, 32'hDE22_BE44);
      chk("rl5_stall_arready", 32'(arready5), 0);
    end
    rready5 = 1'b1;
    @(posedge clk); #1;
    chk("rl5_arready_after", 32'(arready5), 1);
    chk("rl5_rvalid_after", 32'(rvalid5), 0);

    // read sample and write commit on the same word in the same edge
    repeat (10) @(posedge clk);
    #1;
    wr(32'h8000_0020, 32'hAAAA_AAAA, 4'hF, 2'b00, 0);
    exp_b.push_back(2'b00);
    exp_r.push_back('{data: 32'hAAAA_AAAA, resp: 2'b00});
    awaddr = 32'h8000_0020; wdata = 32'h5555_5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_sig(0, c);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8000_0020; arvalid = 1'b1;
    @(negedge clk);
    chk("coll_arready", 32'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd(32'h8000_0020, 32'h5555_5555, 2'b00, 0);

    // asynchronous reset with responses pending
    repeat (10) @(posedge clk);
    #1;
    bready = 1'b0; rready = 1'b0; rready5 = 1'b0;
    awaddr = 32'h8000_0030; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_bvalid", 32'(bvalid), 1);
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    chk("pre_rst_rvalid5", 32'(rvalid5), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_bvalid", 32'(bvalid), 0);
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_wr_count", 32'(wr_count), 0);
    chk("arst_rd_count", 32'(rd_count), 0);
    chk("arst_arready", 32'(arready), 0);
    bready = 1'b1; rready = 1'b1; rready5 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerel_awready", 32'(awready), 1);
    chk("rerel_arready5", 32'(arready5), 1);
    rd(32'h8000_0010, 32'hDE22_BE44, 2'b00, 2);
    chk("post_rst_rd_count", 32'(rd_count), 1);
    chk("post_rst_wr_count", 32'(wr_count), 0);

    repeat (4) @(posedge clk);
    chk("b_queue_drained", 32'(exp_b.size()), 0);
    chk("r_queue_drained", 32'(exp_r.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4lite_mem_responder.md
Name: axi4lite_mem_responder

Overview:
- AXI4-Lite single-beat slave memory that answers the core's external instruction/data AXI initiator port (axi_i_*) of riscv_tcm_top.
- Replaces the constant-zero tie-offs on that port in system benches and in the FPGA top.
- Provides a word-addressed RAM with byte strobes, a programmable read latency, and a decode error for out-of-window accesses.
- Read and write channels are fully independent.

Parameters:
- MEM_BASE, 32'h8000_0000, byte base address of the window.
- MEM_WORDS, 1024, depth in 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1, cycles from AR handshake to rvalid; range 1..15.
- ERR_RDATA, 32'h0, rdata returned on a DECERR read.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- axi_awvalid_i  in  1  write address valid.
- axi_awaddr_i  in  32  write byte address.
- axi_awready_o  out  1  write address ready.
- axi_wvalid_i  in  1  write data valid.
- axi_wdata_i  in  32  write data.
- axi_wstrb_i  in  4  byte strobes; bit n enables wdata[8n+7:8n].
- axi_wready_o  out  1  write data ready.
- axi_bvalid_o  out  1  write response valid.
- axi_bresp_o  out  2  2'b00 OKAY, 2'b11 DECERR.
- axi_bready_i  in  1  write response ready.
- axi_arvalid_i  in  1  read address valid.
- axi_araddr_i  in  32  read byte address.
- axi_arready_o  out  1  read address ready.
- axi_rvalid_o  out  1  read data valid.
- axi_rdata_o  out  32  read data.
- axi_rresp_o  out  2  2'b00 OKAY, 2'b11 DECERR.
- axi_rready_i  in  1  read data ready.
- wr_count_o  out  16  completed B handshakes; wraps at 16'hFFFF->0.
- rd_count_o  out  16  completed R handshakes; wraps.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All outputs are registered and go to 0.
  - awready, wready and arready rise on the first clk_i edge after rst_ni deasserts.
  - RAM contents are not reset.
- Decode:
  - hit = (addr >= MEM_BASE) && (addr < MEM_BASE + 4*MEM_WORDS).
  - Word index = (addr - MEM_BASE)[log2(MEM_WORDS)+1:2]; addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - In W_IDLE, AW and W are accepted independently, in any order or in the same cycle.
  - After an AW handshake, awready=0 until that write's response completes; after a W handshake, wready=0 likewise.
  - When both are held: W_COMMIT, one cycle. If hit, each byte with its strobe set is written; if miss, nothing is written. Then W_RESP.
  - W_RESP: bvalid=1, bresp = OKAY on hit, DECERR on miss. bvalid and bresp stay stable until bready.
  - On the bvalid&&bready cycle: return to W_IDLE, awready=wready=1 on the next cycle, wr_count increments.
  - Minimum latency: last of AW/W handshake at edge N, bvalid at edge N+2.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. The AR handshake latches the address, drops arready, loads a latency counter with READ_LATENCY-1, and goes to R_WAIT.
  - R_WAIT: the counter decrements each cycle. At 0, the RAM (or ERR_RDATA on a miss) is sampled into rdata and the FSM enters R_RESP.
  - rvalid rises exactly READ_LATENCY+1 edges after the AR handshake edge. READ_LATENCY=1 gives rvalid at N+2.
  - R_RESP: rvalid, rdata and rresp stay stable until rready.
  - On the rvalid&&rready cycle: go to R_IDLE, arready=1 next cycle, rd_count increments.
- Only one outstanding transaction per channel; no ID, burst or prot signals.
- Read/write collision: if the read sample and W_COMMIT hit the same word in the same cycle, the read returns the pre-write data.
- A write committed on any earlier cycle is visible to the read.
- Counters are 16-bit unsigned, free-running, wrap without saturation.
- Valid dropped before ready: unsupported (protocol violation); the state machine behaviour is left as-is, no recovery logic.
- Reset mid-transaction: both FSMs return to idle immediately, in-flight responses are discarded, and counters clear.

Test Plan:
- Reset, then AW 0x8000_0010 and W 0xDEADBEEF strb 4'hF in the same cycle, bready=1 -> bvalid 2 cycles later with bresp=00. Read of 0x8000_0010 -> rdata=DEADBEEF, rresp=00, rvalid 2 edges after the AR handshake (READ_LATENCY=1).
- W presented 3 cycles before AW (addr 0x8000_0010, data 0x11223344, strb 4'b0101) -> wready drops after the W handshake and no bvalid appears until AW arrives. Readback = DE22BE44; wr_count=2.
- AW 0x0000_0100 (miss), data 0xFFFFFFFF -> bresp=11 and no RAM change. Read of 0x0000_0100 -> rdata=ERR_RDATA (0), rresp=11.
- READ_LATENCY=5, rready held 0 for 4 cycles after rvalid -> rvalid rises at N+6. rdata stays stable while stalled; arready=0 until the cycle after the R handshake.
- Same-cycle read sample and W_COMMIT to word 0x8000_0020 (old 0xAAAA_AAAA, new 0x5555_5555) -> read returns AAAAAAAA. A subsequent read returns 55555555.
- rst_ni pulsed low while in R_WAIT and W_RESP -> rvalid, bvalid and counters go to 0 asynchronously. Ready signals reassert one edge after release; RAM data is retained.
